stg_latch_hs: RTL and testbench
===============================

Name: stg_latch_hs

Overview:
- Generic, parametrised pipeline-stage register for the diad core. It carries the per-instruction bundle: pc, instr, opc, GP target, SR target and result.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall-cycle counter.
- Instantiated between any two core stages; it replaces the fixed-width, always-advancing stage latches.

Parameters:
- W_ADDR, 24, width of pc field
- W_DATA, 24, width of instr and result fields
- W_OPC, 8, width of opc field
- W_TGT_GP, 4, width of GP target field
- W_TGT_SR, 2, width of SR target field
- BUBBLE_OPC, 0, opc value presented on the output while no valid entry is held
- W_CNT, 16, width of stall counter

Ports:
- iw_clk  in  1  clock, all state updates on rising edge
- iw_rst_n  in  1  synchronous active-low reset
- iw_valid  in  1  upstream bundle valid
- ow_ready  out  1  stage can accept; registered
- iw_flush  in  1  discard all held and incoming entries
- iw_pc  in  W_ADDR  pc
- iw_instr  in  W_DATA  instruction word
- iw_opc  in  W_OPC  decoded opcode
- iw_tgt_gp  in  W_TGT_GP  GP register target
- iw_tgt_sr  in  W_TGT_SR  SR register target
- iw_result  in  W_DATA  result value
- ow_valid  out  1  output bundle valid
- iw_ready  in  1  downstream accepts
- ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result  out  matching widths  registered bundle
- ow_stall_cnt  out  W_CNT  cycles with ow_valid=1 and iw_ready=0

Behaviour:
- Reset is only sampled on the iw_clk edge while iw_rst_n=0. It forces:
  - ow_valid=0, ow_ready=1
  - all ow_ payload fields to 0, except ow_opc=BUBBLE_OPC
  - skid entry empty, ow_stall_cnt=0
- Handshake rules:
  - Accept = iw_valid & ow_ready.
  - Drain = ow_valid & iw_ready.
  - Payload is sampled only on accept.
- Storage: main entry (drives ow_*) and skid entry. State machine:
  - EMPTY: ow_valid=0, ow_ready=1. Accept -> ONE; the bundle appears on ow_* the next cycle (latency 1).
  - ONE:
    - accept & drain -> ONE, main loaded with new bundle (throughput 1/cycle)
    - accept & !drain -> FULL, new bundle to skid, main unchanged
    - !accept & drain -> EMPTY
    - otherwise hold
  - FULL: ow_ready=0, so no accept. Drain -> ONE, with skid moved into main the same edge.
- ow_ready is a flop equal to "next state != FULL". Combinational iw_ready->ow_ready paths are forbidden.
- Order: strictly FIFO; no bundle is duplicated or dropped except by flush.
- Flush (iw_flush=1 at the edge):
  - Next state EMPTY; ow_valid=0, ow_ready=1.
  - ow_opc=BUBBLE_OPC; other payload fields hold their last values.
  - A simultaneous accept is discarded.
  - A simultaneous drain still counts downstream (the bundle was taken), but the stage does not refill.
  - Flush has priority over every transition; reset has priority over flush.
- Payload fields while ow_valid=0: ow_opc=BUBBLE_OPC, others hold their last values. Downstream must qualify on ow_valid.
- Stall counter: increments by 1 on each edge where ow_valid=1 & iw_ready=0 & iw_flush=0. It saturates at all-ones with no wrap and is cleared only by reset.
- Reset mid-operation: held entries are lost, the state returns to EMPTY on the reset edge, and the first accept is allowed on the first edge with iw_rst_n=1.
- No X propagation: every flop is reset.

Test Plan:
- Reset: hold iw_rst_n=0 for 2 cycles with iw_valid=1 and pc=0x000123 -> ow_valid=0, ow_ready=1, ow_opc=BUBBLE_OPC, ow_stall_cnt=0; the 0x000123 bundle is not captured.
- Streaming: iw_ready=1, send pc=1..8 back-to-back -> ow_pc=1..8 on consecutive cycles, each 1 cycle after acceptance; ow_ready stays 1.
- Backpressure/skid:
  - Send pc=0x10, 0x11, 0x12 with iw_ready=0 from cycle 1 -> 0x10 in main, 0x11 in skid, ow_ready=0, 0x12 held upstream, ow_stall_cnt increments each stalled cycle.
  - Release iw_ready -> output order 0x10, 0x11, 0x12, no loss.
- Flush: in FULL, assert iw_flush with iw_valid=1 (pc=0x20) -> next cycle ow_valid=0, ow_opc=BUBBLE_OPC, ow_ready=1; 0x20 is never output.
- Counter saturation: W_CNT=4, hold ow_valid=1 with iw_ready=0 for 20 cycles -> ow_stall_cnt=15, stays 15.
- Reset mid-op: in FULL, pulse iw_rst_n=0 for one edge -> EMPTY, counter 0; the next bundle, pc=0x30, emerges alone.

Source files
------------

// File: rtl/stg_latch_hs.sv
// stg_latch_hs -- parametrised pipeline-stage register for the diad core.
//
// Carries one instruction bundle (pc, instr, opc, GP target, SR target,
// result) between two core stages with a valid/ready handshake. A second
// (skid) entry absorbs the one extra bundle that can arrive in the cycle
// where downstream stalls, so ow_ready can be a plain flop.
//
// Ports:
//   iw_clk, iw_rst_n        clock, synchronous active-low reset
//   iw_valid / ow_ready     upstream handshake (ow_ready registered)
//   iw_flush                discard held and incoming entries
//   iw_pc .. iw_result      incoming bundle
//   ow_valid / iw_ready     downstream handshake
//   ow_pc .. ow_result      registered outgoing bundle (opc = BUBBLE_OPC when empty)
//   ow_stall_cnt            saturating count of cycles with ow_valid & !iw_ready
module stg_latch_hs #(
  parameter int W_ADDR     = 24,
  parameter int W_DATA     = 24,
  parameter int W_OPC      = 8,
  parameter int W_TGT_GP   = 4,
  parameter int W_TGT_SR   = 2,
  parameter int BUBBLE_OPC = 0,
  parameter int W_CNT      = 16
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_valid,
  output logic                ow_ready,
  input  logic                iw_flush,
  input  logic [W_ADDR-1:0]   iw_pc,
  input  logic [W_DATA-1:0]   iw_instr,
  input  logic [W_OPC-1:0]    iw_opc,
  input  logic [W_TGT_GP-1:0] iw_tgt_gp,
  input  logic [W_TGT_SR-1:0] iw_tgt_sr,
  input  logic [W_DATA-1:0]   iw_result,
  output logic                ow_valid,
  input  logic                iw_ready,
  output logic [W_ADDR-1:0]   ow_pc,
  output logic [W_DATA-1:0]   ow_instr,
  output logic [W_OPC-1:0]    ow_opc,
  output logic [W_TGT_GP-1:0] ow_tgt_gp,
  output logic [W_TGT_SR-1:0] ow_tgt_sr,
  output logic [W_DATA-1:0]   ow_result,
  output logic [W_CNT-1:0]    ow_stall_cnt
);

  localparam logic [W_OPC-1:0] BUB = W_OPC'(BUBBLE_OPC);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [W_CNT-1:0]    cnt_q, cnt_d;

  // Main entry: drives the outputs directly.
  logic [W_ADDR-1:0]   pc_q, pc_d;
  logic [W_DATA-1:0]   instr_q, instr_d;
  logic [W_OPC-1:0]    opc_q, opc_d;
  logic [W_TGT_GP-1:0] gp_q, gp_d;
  logic [W_TGT_SR-1:0] sr_q, sr_d;
  logic [W_DATA-1:0]   res_q, res_d;

  // Skid entry: only meaningful in ST_FULL.
  logic [W_ADDR-1:0]   sk_pc_q, sk_pc_d;
  logic [W_DATA-1:0]   sk_instr_q, sk_instr_d;
  logic [W_OPC-1:0]    sk_opc_q, sk_opc_d;
  logic [W_TGT_GP-1:0] sk_gp_q, sk_gp_d;
  logic [W_TGT_SR-1:0] sk_sr_q, sk_sr_d;
  logic [W_DATA-1:0]   sk_res_q, sk_res_d;

  logic accept, drain;

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + W_CNT'(1);
  endfunction

  // ready_q is a flop, so there is no combinational iw_ready -> ow_ready path.
  assign accept = iw_valid & ready_q;
  assign drain  = valid_q & iw_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    gp_d       = gp_q;
    sr_d       = sr_q;
    res_d      = res_q;
    sk_pc_d    = sk_pc_q;
    sk_instr_d = sk_instr_q;
    sk_opc_d   = sk_opc_q;
    sk_gp_d    = sk_gp_q;
    sk_sr_d    = sk_sr_q;
    sk_res_d   = sk_res_q;

    if (valid_q && !iw_ready && !iw_flush) cnt_d = sat_inc(cnt_q);

    if (iw_flush) begin
      // Bubble out; non-opc payload keeps its last value.
      state_d = ST_EMPTY;
      opc_d   = BUB;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            pc_d = iw_pc; instr_d = iw_instr; opc_d = iw_opc;
            gp_d = iw_tgt_gp; sr_d = iw_tgt_sr; res_d = iw_result;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            pc_d = iw_pc; instr_d = iw_instr; opc_d = iw_opc;
            gp_d = iw_tgt_gp; sr_d = iw_tgt_sr; res_d = iw_result;
          end else if (accept) begin
            state_d = ST_FULL;
            sk_pc_d = iw_pc; sk_instr_d = iw_instr; sk_opc_d = iw_opc;
            sk_gp_d = iw_tgt_gp; sk_sr_d = iw_tgt_sr; sk_res_d = iw_result;
          end else if (drain) begin
            state_d = ST_EMPTY;
            opc_d   = BUB;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d = ST_ONE;
            pc_d = sk_pc_q; instr_d = sk_instr_q; opc_d = sk_opc_q;
            gp_d = sk_gp_q; sr_d = sk_sr_q; res_d = sk_res_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q    <= ST_EMPTY;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      opc_q      <= BUB;
      gp_q       <= '0;
      sr_q       <= '0;
      res_q      <= '0;
      sk_pc_q    <= '0;
      sk_instr_q <= '0;
      sk_opc_q   <= '0;
      sk_gp_q    <= '0;
      sk_sr_q    <= '0;
      sk_res_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opc_q      <= opc_d;
      gp_q       <= gp_d;
      sr_q       <= sr_d;
      res_q      <= res_d;
      sk_pc_q    <= sk_pc_d;
      sk_instr_q <= sk_instr_d;
      sk_opc_q   <= sk_opc_d;
      sk_gp_q    <= sk_gp_d;
      sk_sr_q    <= sk_sr_d;
      sk_res_q   <= sk_res_d;
    end
  end

  assign ow_valid     = valid_q;
  assign ow_ready     = ready_q;
  assign ow_pc        = pc_q;
  assign ow_instr     = instr_q;
  assign ow_opc       = opc_q;
  assign ow_tgt_gp    = gp_q;
  assign ow_tgt_sr    = sr_q;
  assign ow_result    = res_q;
  assign ow_stall_cnt = cnt_q;

endmodule

// File: tb/tb_stg_latch_hs.sv
module tb_stg_latch_hs;

  localparam int W_CNT   = 4;
  localparam int BUB_INT = 165;
  localparam logic [7:0] BUB = 8'hA5;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic        clk = 1'b0;
  logic        rst_n, iw_valid, iw_flush, iw_ready;
  logic [23:0] iw_pc, iw_instr, iw_result;
  logic [7:0]  iw_opc;
  logic [3:0]  iw_tgt_gp;
  logic [1:0]  iw_tgt_sr;
  logic        ow_ready, ow_valid;
  logic [23:0] ow_pc, ow_instr, ow_result;
  logic [7:0]  ow_opc;
  logic [3:0]  ow_tgt_gp;
  logic [1:0]  ow_tgt_sr;
  logic [W_CNT-1:0] ow_stall_cnt;

  always #5 clk = ~clk;

  stg_latch_hs #(.BUBBLE_OPC(BUB_INT), .W_CNT(W_CNT)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_valid(iw_valid), .ow_ready(ow_ready),
    .iw_flush(iw_flush), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr), .iw_result(iw_result),
    .ow_valid(ow_valid), .iw_ready(iw_ready), .ow_pc(ow_pc), .ow_instr(ow_instr),
    .ow_opc(ow_opc), .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr),
    .ow_result(ow_result), .ow_stall_cnt(ow_stall_cnt)
  );

  typedef struct {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [7:0]  opc;
    logic [3:0]  gp;
    logic [1:0]  sr;
    logic [23:0] res;
  } bnd_t;

  // Model: a FIFO of at most two held bundles, plus what is on the outputs.
  bnd_t q[$];
  bnd_t shown;
  int   m_cnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bnd_t inb, tmp;
    bit acc, drn;
    inb.pc = iw_pc; inb.instr = iw_instr; inb.opc = iw_opc;
    inb.gp = iw_tgt_gp; inb.sr = iw_tgt_sr; inb.res = iw_result;
    acc = iw_valid && (q.size() < 2);
    drn = (q.size() > 0) && iw_ready;
    if (!rst_n) begin
      q.delete();
      shown.pc = '0; shown.instr = '0; shown.opc = BUB;
      shown.gp = '0; shown.sr = '0; shown.res = '0;
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !iw_ready && !iw_flush && m_cnt < CNT_MAX) m_cnt++;
      if (iw_flush) begin
        q.delete();
        shown.opc = BUB;
      end else begin
        if (drn) tmp = q.pop_front();
        if (acc) q.push_back(inb);
        if (q.size() > 0) shown = q[0];
        else shown.opc = BUB;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", {31'd0, ow_valid}, {31'd0, q.size() > 0});
    chk("ready", {31'd0, ow_ready}, {31'd0, q.size() < 2});
    chk("pc", {8'd0, ow_pc}, {8'd0, shown.pc});
    chk("instr", {8'd0, ow_instr}, {8'd0, shown.instr});
    chk("opc", {24'd0, ow_opc}, {24'd0, shown.opc});
    chk("gp", {28'd0, ow_tgt_gp}, {28'd0, shown.gp});
    chk("sr", {30'd0, ow_tgt_sr}, {30'd0, shown.sr});
    chk("result", {8'd0, ow_result}, {8'd0, shown.res});
    chk("stall_cnt", 32'(ow_stall_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drv(input logic v, input logic [23:0] pc);
    iw_valid  = v;
    iw_pc     = pc;
    iw_instr  = 24'($urandom);
    iw_opc    = 8'($urandom);
    iw_tgt_gp = 4'($urandom);
    iw_tgt_sr = 2'($urandom);
    iw_result = 24'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; iw_flush = 1'b0; iw_ready = 1'b1;
    q.delete(); m_cnt = 0;
    drv(1'b1, 24'h000123);
    #1;
    // Reset held two edges with a valid bundle present.
    step(); step();
    chk("rst_valid", {31'd0, ow_valid}, 32'd0);
    chk("rst_ready", {31'd0, ow_ready}, 32'd1);
    chk("rst_opc", {24'd0, ow_opc}, 32'hA5);
    chk("rst_cnt", 32'(ow_stall_cnt), 32'd0);
    rst_n = 1'b1; drv(1'b0, 24'h0); step();
    chk("rst_no_capture", {31'd0, ow_valid}, 32'd0);

    // Streaming pc=1..8.
    iw_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 24'(i)); step();
      chk("stream_pc", {8'd0, ow_pc}, 32'(i));
      chk("stream_ready", {31'd0, ow_ready}, 32'd1);
    end
    drv(1'b0, 24'h0); step();
    chk("stream_end_valid", {31'd0, ow_valid}, 32'd0);

    // Backpressure into the skid entry.
    iw_ready = 1'b0;
    drv(1'b1, 24'h10); step();
    drv(1'b1, 24'h11); step();
    chk("bp_full_ready", {31'd0, ow_ready}, 32'd0);
    drv(1'b1, 24'h12);
    for (int i = 0; i < 3; i++) step();
    chk("bp_main_pc", {8'd0, ow_pc}, 32'h10);
    chk("bp_cnt", 32'(ow_stall_cnt), 32'd4);
    iw_ready = 1'b1; step();
    chk("bp_out2", {8'd0, ow_pc}, 32'h11);
    step();
    chk("bp_out3", {8'd0, ow_pc}, 32'h12);
    drv(1'b0, 24'h0); step();

    // Flush while FULL with an incoming bundle.
    iw_ready = 1'b0;
    drv(1'b1, 24'h40); step();
    drv(1'b1, 24'h41); step();
    drv(1'b1, 24'h20); iw_flush = 1'b1; step();
    chk("flush_valid", {31'd0, ow_valid}, 32'd0);
    chk("flush_opc", {24'd0, ow_opc}, 32'hA5);
    chk("flush_ready", {31'd0, ow_ready}, 32'd1);
    chk("flush_pc_hold", {8'd0, ow_pc}, 32'h40);
    iw_flush = 1'b0; drv(1'b0, 24'h0); iw_ready = 1'b1; step();
    chk("flush_no_0x20", {31'd0, ow_valid}, 32'd0);

    // Counter saturation.
    iw_ready = 1'b0;
    drv(1'b1, 24'h50); step();
    drv(1'b0, 24'h0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(ow_stall_cnt), 32'd15);
    step();
    chk("sat_cnt_hold", 32'(ow_stall_cnt), 32'd15);

    // Reset in the middle of operation.
    drv(1'b1, 24'h51); step();
    chk("midrst_full", {31'd0, ow_ready}, 32'd0);
    rst_n = 1'b0; drv(1'b0, 24'h0); step();
    chk("midrst_valid", {31'd0, ow_valid}, 32'd0);
    chk("midrst_cnt", 32'(ow_stall_cnt), 32'd0);
    rst_n = 1'b1; iw_ready = 1'b1; drv(1'b1, 24'h30); step();
    chk("midrst_pc30", {8'd0, ow_pc}, 32'h30);
    drv(1'b0, 24'h0); step();
    chk("midrst_alone", {31'd0, ow_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drv(1'($urandom_range(0, 3) != 0), 24'($urandom));
      iw_ready = 1'($urandom_range(0, 2) != 0);
      iw_flush = ($urandom_range(0, 24) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
